dsp_stream_adapter: RTL and testbench



---
 rtl/dsp_stream_pkg.sv | 17 +
 rtl/dsp_stream_adapter_if.sv | 30 +++
 rtl/add_mul_and_pipe.sv | 65 ++++++
 rtl/dsp_stream_adapter.sv | 97 +++++++++
 tb/tb_dsp_stream_adapter.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/dsp_stream_pkg.sv
// Shared defaults and types for the DSP stream adapter.
//   WIDTH   : default operand/result width
//   LATENCY : default core pipeline depth
//   res_t   : result word at the default width
//   ptr_width(depth) : index width for a buffer of 'depth' entries (min 1)
package dsp_stream_pkg;

  localparam int unsigned WIDTH   = 9;
  localparam int unsigned LATENCY = 3;

  typedef logic [WIDTH-1:0] res_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dsp_stream_adapter_if.sv
// Stream bundle between producer/consumer and the adapter.
//   in_valid/in_ready   : operand tuple handshake (a, b, c, d)
//   out_valid/out_ready : result handshake (out_data)
// master : environment side (drives operands and out_ready)
// slave  : adapter side (drives in_ready and the result)
interface dsp_stream_adapter_if #(
  parameter int unsigned WIDTH = dsp_stream_pkg::WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, a, b, c, d, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, a, b, c, d, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/add_mul_and_pipe.sv
// Free-running ((d + a) * b) & c pipeline, WIDTH-bit modular arithmetic.
// No reset, valid or enable so it maps onto a DSP slice (AD, M, P registers).
//   clk   : clock
//   a_i..d_i : operands, captured every cycle
//   res_o : result, LATENCY cycles after the operands were presented
module add_mul_and_pipe #(
  parameter int unsigned WIDTH   = dsp_stream_pkg::WIDTH,
  parameter int unsigned LATENCY = dsp_stream_pkg::LATENCY
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] res_o
);

  if (LATENCY == 1) begin : g_lat1
    logic [WIDTH-1:0] sum, prod, res_q;
    always_comb begin
      sum  = d_i + a_i;
      prod = sum * b_i;
    end
    always_ff @(posedge clk) begin
      res_q <= prod & c_i;
    end
    assign res_o = res_q;

  end else if (LATENCY == 2) begin : g_lat2
    logic [WIDTH-1:0] sum_q, b_q, c_q, res_q;
    always_ff @(posedge clk) begin
      sum_q <= d_i + a_i;
      b_q   <= b_i;
      c_q   <= c_i;
      res_q <= (sum_q * b_q) & c_q;
    end
    assign res_o = res_q;

  end else begin : g_lat3p
    // Pre-adder, multiplier and logic-unit registers, then a plain delay line.
    logic [WIDTH-1:0] sum_q, b_q, c_q, prod_q, c1_q, p_q;
    always_ff @(posedge clk) begin
      sum_q  <= d_i + a_i;
      b_q    <= b_i;
      c_q    <= c_i;
      prod_q <= sum_q * b_q;
      c1_q   <= c_q;
      p_q    <= prod_q & c1_q;
    end

    if (LATENCY == 3) begin : g_nodly
      assign res_o = p_q;
    end else begin : g_dly
      logic [WIDTH-1:0] dly_q [LATENCY-3];
      always_ff @(posedge clk) begin
        dly_q[0] <= p_q;
        for (int i = 1; i < int'(LATENCY - 3); i++) begin
          dly_q[i] <= dly_q[i-1];
        end
      end
      assign res_o = dly_q[LATENCY-4];
    end
  end

endmodule

// File: rtl/dsp_stream_adapter.sv
// Valid/ready wrapper around the free-running add_mul_and_pipe core.
// A valid shift register tracks tuples in flight; a credit-gated result FIFO
// absorbs backpressure so the core never has to stall.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus_io     : stream bundle (slave side): operands in, results out
module dsp_stream_adapter #(
  parameter int unsigned WIDTH      = dsp_stream_pkg::WIDTH,
  parameter int unsigned LATENCY    = dsp_stream_pkg::LATENCY,
  parameter int unsigned FIFO_DEPTH = LATENCY + 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dsp_stream_adapter_if.slave  bus_io
);

  localparam int unsigned PtrW = dsp_stream_pkg::ptr_width(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic [WIDTH-1:0]   core_res;
  logic [LATENCY-1:0] v_q, v_d;
  logic [WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               in_ready, accept, push, pop;

  add_mul_and_pipe #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_core (
    .clk   (clk),
    .a_i   (bus_io.a),
    .b_i   (bus_io.b),
    .c_i   (bus_io.c),
    .d_i   (bus_io.d),
    .res_o (core_res)
  );

  // Credit: every tuple in flight already owns a FIFO slot, so a write is
  // never refused. Only registered state feeds in_ready.
  always_comb begin
    int unsigned occupancy;
    occupancy = 32'(cnt_q);
    for (int i = 0; i < int'(LATENCY); i++) begin
      occupancy = occupancy + 32'(v_q[i]);
    end
    in_ready = occupancy < FIFO_DEPTH;
  end

  assign accept = bus_io.in_valid && in_ready;
  assign push   = v_q[LATENCY-1];
  assign pop    = (cnt_q != '0) && bus_io.out_ready;

  always_comb begin
    v_d    = v_q << 1;
    v_d[0] = accept;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q      <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      v_q      <= v_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= core_res;
      end
    end
  end

  assign bus_io.in_ready  = in_ready;
  assign bus_io.out_valid = cnt_q != '0;
  assign bus_io.out_data  = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_dsp_stream_adapter.sv
// Scoreboard bench for dsp_stream_adapter (WIDTH=9, LATENCY=3, FIFO_DEPTH=5).
module tb_dsp_stream_adapter;

  localparam int W     = 9;
  localparam int LAT   = 3;
  localparam int DEPTH = 5;

  typedef struct {
    logic [W-1:0] data;
    int           acc_cyc;
    bit           chk_lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  dsp_stream_adapter_if #(.WIDTH(W)) bus ();

  dsp_stream_adapter #(
    .WIDTH      (W),
    .LATENCY    (LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  function automatic logic [W-1:0] model(input logic [W-1:0] a, b, c, d);
    logic [W-1:0] s, p;
    s = d + a;
    p = s * b;
    return p & c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops on every output handshake and compares against the queue.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (dut.v_q[LAT-1] && dut.cnt_q == DEPTH && !(bus.out_valid && bus.out_ready)) begin
        n_err++;
        $display("FAIL fifo_overflow: push into full FIFO at cycle %0d", cyc);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got %0h, required no output", bus.out_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_data", 32'(bus.out_data), 32'(e.data));
          if (e.chk_lat) check("latency", cyc - e.acc_cyc, LAT + 1);
        end
      end
    end
  end

  // Present one tuple for one cycle; expected result is queued on acceptance.
  task automatic step(input bit v, input logic [W-1:0] a, b, c, d, exp_v,
                      input bit lat, output bit got);
    bus.in_valid = v;
    bus.a = a; bus.b = b; bus.c = c; bus.d = d;
    @(negedge clk);
    got = v && bus.in_ready;
    if (got) sb.push_back('{data: exp_v, acc_cyc: cyc, chk_lat: lat});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit got;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0, '0, 1'b0, got);
  endtask

  task automatic drain(input string name);
    int n = 0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    while ((sb.size() != 0 || bus.out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 32'(sb.size()), 0);
  endtask

  // Directed vectors: a, b, c, d, hand-computed result.
  logic [W-1:0] vec [3][5];

  initial begin
    bit got;
    int n_got;
    logic [W-1:0] ra, rb, rc, rd;
    vec[0] = '{9'd3,   9'd5,  9'h1FF, 9'd4, 9'd35};
    vec[1] = '{9'h1FF, 9'd7,  9'h1FF, 9'd1, 9'd0};
    vec[2] = '{9'd20,  9'd30, 9'h0FF, 9'd0, 9'd88};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("reset_in_ready", 32'(bus.in_ready), 1);
    check("reset_out_valid", 32'(bus.out_valid), 0);
    check("reset_out_data", 32'(bus.out_data), 0);
    @(posedge clk); #1;

    // Single op, then the two wrap cases back to back.
    bus.out_ready = 1'b1;
    step(1'b1, vec[0][0], vec[0][1], vec[0][2], vec[0][3], vec[0][4], 1'b1, got);
    check("single_accept", 32'(got), 1);
    idle(6);
    drain("single_drain");
    for (int i = 1; i < 3; i++)
      step(1'b1, vec[i][0], vec[i][1], vec[i][2], vec[i][3], vec[i][4], 1'b1, got);
    drain("wrap_drain");

    // Throughput: 20 back-to-back with out_ready=1.
    n_got = 0;
    for (int i = 0; i < 20; i++) begin
      ra = 9'(i * 7); rb = 9'(i + 3); rc = 9'h1F0 ^ 9'(i); rd = 9'(100 + i);
      step(1'b1, ra, rb, rc, rd, model(ra, rb, rc, rd), 1'b1, got);
      n_got += int'(got);
    end
    check("thru_accepts", n_got, 20);
    drain("thru_drain");

    // Backpressure: exactly DEPTH accepted, then in_ready low until a pop.
    bus.out_ready = 1'b0;
    n_got = 0;
    for (int i = 0; i < 12; i++) begin
      ra = 9'(n_got + 1); rb = 9'(n_got + 2); rc = 9'h1FF; rd = 9'(n_got * 3);
      step(1'b1, ra, rb, rc, rd, model(ra, rb, rc, rd), 1'b0, got);
      n_got += int'(got);
    end
    check("bp_accepts", n_got, DEPTH);
    check("bp_in_ready_low", 32'(bus.in_ready), 0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_at_pop", 32'(bus.in_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_ready_after_pop", 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    drain("bp_drain");

    // Random stalls over 1000 accepted ops.
    begin
      int acc = 0;
      int budget = 0;
      while (acc < 1000 && budget < 20000) begin
        ra = 9'($urandom_range(0, 511)); rb = 9'($urandom_range(0, 511));
        rc = 9'($urandom_range(0, 511)); rd = 9'($urandom_range(0, 511));
        got = 1'b0;
        while (!got && budget < 20000) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          step($urandom_range(0, 3) != 0, ra, rb, rc, rd, model(ra, rb, rc, rd), 1'b0, got);
          budget++;
        end
        acc += int'(got);
      end
      check("rand_accepts", acc, 1000);
    end
    drain("rand_drain");

    // Reset with 3 in flight and 2 buffered.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ra = 9'(50 + i); rb = 9'(9 + i); rc = 9'h1FF; rd = 9'(i);
      step(1'b1, ra, rb, rc, rd, model(ra, rb, rc, rd), 1'b0, got);
    end
    check("rst_pre_out_valid", 32'(bus.out_valid), 1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("rst_out_valid_now", 32'(bus.out_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_data", 32'(bus.out_data), 0);
    bus.out_ready = 1'b1;
    idle(10);
    check("rst_no_stale", 32'(bus.out_valid), 0);
    step(1'b1, vec[0][0], vec[0][1], vec[0][2], vec[0][3], vec[0][4], 1'b1, got);
    drain("post_rst_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
